jtframe_rom_arbiter: RTL

- Shares the single game-side SDRAM read port (sdram_req/sdram_addr/sdram_ack/data_rdy/data_read) among SLOTS ROM requesters inside a game top, e.g. CPU, char, scroll, object and sound ROM fetchers.
- Uses round-robin grant.
- Holds off all traffic while a ROM download or loop reset is active.
- Drives refresh_en so the SDRAM controller refreshes only when the port is idle.

---
 rtl/jtframe_rom_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/jtframe_rom_arbiter.sv
// ----------------------------------------------------------------------------
// jtframe_rom_arbiter
//
// Shares the game-side SDRAM read port among SLOTS ROM requesters with a
// round-robin grant. Each requester holds slot_req until it receives its
// one-cycle slot_ok pulse. All traffic is held off while a ROM download or
// an SDRAM loop reset is in progress. Refresh is only permitted while the
// port is idle.
//
// Ports:
//   clk_sys      system clock
//   RESET        asynchronous, active-high reset
//   downloading  ROM download in progress (blocks arbitration)
//   loop_rst     SDRAM controller loop reset (blocks arbitration)
//   slot_req     per-slot level request, held until slot_ok
//   slot_addr    packed slot addresses, slot i at [i*AW +: AW]
//   slot_ok      one-hot, one-cycle completion pulse
//   slot_dout    read data, valid with slot_ok, held until next completion
//   sdram_req    request to SDRAM controller
//   sdram_addr   latched address of the granted slot
//   sdram_ack    controller accepted the request
//   data_rdy     data_read is valid
//   data_read    SDRAM read data
//   refresh_en   SDRAM refresh permitted
//   grant        index of the slot being served (meaningful while busy)
//   busy         arbiter not idle
//   timeout_err  sticky: a transaction timed out waiting for data
// ----------------------------------------------------------------------------
module jtframe_rom_arbiter #(
   parameter int SLOTS   = 4,
   parameter int AW      = 22,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk_sys,
   input  logic                RESET,
   input  logic                downloading,
   input  logic                loop_rst,
   input  logic [SLOTS-1:0]    slot_req,
   input  logic [SLOTS*AW-1:0] slot_addr,
   output logic [SLOTS-1:0]    slot_ok,
   output logic [DW-1:0]       slot_dout,
   output logic                sdram_req,
   output logic [AW-1:0]       sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic [DW-1:0]       data_read,
   output logic                refresh_en,
   output logic [2:0]          grant,
   output logic                busy,
   output logic                timeout_err
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DATA = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [2:0]        grant_next;
   logic [2:0]        ptr_reg, ptr_next;
   logic              sdram_req_next;
   logic [AW-1:0]     sdram_addr_next;
   logic [SLOTS-1:0]  slot_ok_next;
   logic [DW-1:0]     slot_dout_next;
   logic [7:0]        cnt_reg, cnt_next;
   logic              timeout_err_next;

   logic              block;
   logic              found;
   logic [2:0]        sel;
   logic [3:0]        idx;
   logic [AW-1:0]     sel_addr;
   logic [SLOTS-1:0]  grant_onehot;
   logic [AW-1:0]     addr_arr [SLOTS];

   assign block = downloading | loop_rst;

   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_addr
         assign addr_arr[gi] = slot_addr[gi*AW +: AW];
      end
   endgenerate

   // Round-robin scan: offsets 1..SLOTS from the last grant, so the slot
   // served last has the lowest priority next time.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 1; k <= SLOTS; k++) begin
         idx = {1'b0, ptr_reg} + 4'(k);
         if (idx >= 4'(SLOTS)) idx = idx - 4'(SLOTS);
         for (int i = 0; i < SLOTS; i++) begin
            if (!found && idx == 4'(i) && slot_req[i]) begin
               found = 1'b1;
               sel   = 3'(i);
            end
         end
      end
   end

   // Explicit compare-mux keeps index widths exact for any SLOTS.
   always_comb begin
      sel_addr     = '0;
      grant_onehot = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (sel == 3'(i))   sel_addr        = addr_arr[i];
         if (grant == 3'(i)) grant_onehot[i] = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state_reg   <= IDLE;
         grant       <= '0;
         ptr_reg     <= 3'(SLOTS-1);
         sdram_req   <= 1'b0;
         sdram_addr  <= '0;
         slot_ok     <= '0;
         slot_dout   <= '0;
         cnt_reg     <= '0;
         timeout_err <= 1'b0;
      end else begin
         state_reg   <= state_next;
         grant       <= grant_next;
         ptr_reg     <= ptr_next;
         sdram_req   <= sdram_req_next;
         sdram_addr  <= sdram_addr_next;
         slot_ok     <= slot_ok_next;
         slot_dout   <= slot_dout_next;
         cnt_reg     <= cnt_next;
         timeout_err <= timeout_err_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      grant_next       = grant;
      ptr_next         = ptr_reg;
      sdram_req_next   = sdram_req;
      sdram_addr_next  = sdram_addr;
      slot_ok_next     = '0;
      slot_dout_next   = slot_dout;
      cnt_next         = cnt_reg;
      timeout_err_next = timeout_err;

      case (state_reg)
         IDLE: begin
            if (!block && found) begin
               grant_next      = sel;
               sdram_addr_next = sel_addr;
               sdram_req_next  = 1'b1;
               state_next      = WAIT_ACK;
            end
         end

         WAIT_ACK: begin
            if (block) begin
               // Abort without touching the pointer: same slot wins again.
               sdram_req_next = 1'b0;
               state_next     = IDLE;
            end else if (sdram_ack) begin
               sdram_req_next = 1'b0;
               cnt_next       = '0;
               if (data_rdy) begin
                  // Data arrived together with the ack: skip WAIT_DATA.
                  slot_dout_next = data_read;
                  slot_ok_next   = grant_onehot;
                  ptr_next       = grant;
                  state_next     = IDLE;
               end else begin
                  state_next = WAIT_DATA;
               end
            end
         end

         WAIT_DATA: begin
            if (block) begin
               state_next = IDLE;
            end else if (data_rdy) begin
               slot_dout_next = data_read;
               slot_ok_next   = grant_onehot;
               ptr_next       = grant;
               state_next     = IDLE;
            end else if (cnt_reg == 8'(TIMEOUT-1)) begin
               // TIMEOUT cycles spent in WAIT_DATA without data: give up.
               timeout_err_next = 1'b1;
               ptr_next         = grant;
               state_next       = IDLE;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end

         default: begin
            sdram_req_next = 1'b0;
            state_next     = IDLE;
         end
      endcase
   end

   assign busy = (state_reg != IDLE);

   // Refresh allowed while idle and not starting a request this cycle,
   // and always while traffic is blocked or the arbiter is held in reset.
   assign refresh_en = RESET | block | ((state_reg == IDLE) & ~found);

endmodule
